// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg : shared types and helpers for the pipeline hazard unit    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } mem_state_t;

  localparam logic [3:0] REG_PC = 4'd15;

  // The PC is read directly in E, so it is never a forwarding target.
  function automatic fwd_sel_t fwd_sel(
    input logic       reg_write_m,
    input logic [3:0] wa3_m,
    input logic       reg_write_w,
    input logic [3:0] wa3_w,
    input logic [3:0] ra_e
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ra_e != REG_PC) begin
      if (reg_write_m && (wa3_m == ra_e))      sel = FWD_MEM;
      else if (reg_write_w && (wa3_w == ra_e)) sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wait_fsm : inserts MEM_LAT stall cycles per data-memory access    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic MemReqM,
  output logic memStall,
  output logic busy
);

  localparam int c_CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

  generate
    if (MEM_LAT == 0) begin : g_no_wait
      assign memStall = 1'b0;
      assign busy     = 1'b0;
    end else begin : g_wait
      localparam logic [c_CW-1:0] c_LOAD = c_CW'(MEM_LAT - 1);
      localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

      mem_state_t       r_state;
      mem_state_t       w_state_nxt;
      logic [c_CW-1:0]  r_cnt;
      logic [c_CW-1:0]  w_cnt_nxt;
      logic             w_stall;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
        end
      end

      // GRANT ignores MemReqM so a following access re-enters from IDLE.
      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
          IDLE: begin
            if (MemReqM) begin
              w_stall = 1'b1;
              if (MEM_LAT == 1) begin
                w_state_nxt = GRANT;
              end else begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = c_LOAD;
              end
            end
          end
          WAIT: begin
            w_stall   = 1'b1;
            w_cnt_nxt = r_cnt - c_ONE;
            if (r_cnt == c_ONE) w_state_nxt = GRANT;
          end
          GRANT:   w_state_nxt = IDLE;
          default: w_state_nxt = IDLE;
        endcase
      end

      assign memStall = rst & w_stall;
      assign busy     = (r_state != IDLE);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_controller : forwarding, stall/flush sequencing, stall counter |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       Ra1D,
  input  logic [3:0]       Ra2D,
  input  logic [3:0]       Ra1E,
  input  logic [3:0]       Ra2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemReqM,
  input  logic             PCSrcE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             w_mem_stall;
  logic             w_ld_stall;
  logic [CNT_W-1:0] r_stall_cycles;

  mem_wait_fsm #(
    .MEM_LAT (MEM_LAT)
  ) u_mem_wait_fsm (
    .clk      (clk),
    .rst      (rst),
    .MemReqM  (MemReqM),
    .memStall (w_mem_stall),
    .busy     (mem_busy)
  );

  assign ForwardAE  = fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, Ra1E);
  assign ForwardBE  = fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, Ra2E);
  assign w_ld_stall = MemtoRegE & ((WA3E == Ra1D) | (WA3E == Ra2D));

  // A memory stall freezes E, so branch/load-use are re-evaluated on release.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = w_ld_stall;
      StallD = w_ld_stall;
      FlushD = PCSrcE;
      FlushE = w_ld_stall | PCSrcE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
    end else if (StallF && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_controller : directed self-checking bench                   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_hazard_controller;

  logic       clk;
  logic       rst;
  logic [3:0] Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE, MemReqM, PCSrcE;

  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_busy;
  logic [3:0] stall_cycles;

  logic [1:0] ForwardAE0, ForwardBE0;
  logic       StallF0, StallD0, StallE0, StallM0, FlushD0, FlushE0, FlushW0, mem_busy0;
  logic [3:0] stall_cycles0;

  int errors = 0;
  int checks = 0;

  hazard_controller #(.MEM_LAT(2), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .MemReqM(MemReqM), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .mem_busy(mem_busy), .stall_cycles(stall_cycles)
  );

  hazard_controller #(.MEM_LAT(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .MemReqM(MemReqM), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE0), .ForwardBE(ForwardBE0),
    .StallF(StallF0), .StallD(StallD0), .StallE(StallE0), .StallM(StallM0),
    .FlushD(FlushD0), .FlushE(FlushE0), .FlushW(FlushW0),
    .mem_busy(mem_busy0), .stall_cycles(stall_cycles0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    Ra1D = 4'd0; Ra2D = 4'd0; Ra1E = 4'd0; Ra2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    MemReqM = 1'b0; PCSrcE = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    MemReqM = 1'b1;
    #3;
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", mem_busy); end
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", stall_cycles); end
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stallm: got %b exp 0", StallM); end
    checks++; if (FlushW !== 1'b0) begin errors++; $display("FAIL reset_flushw: got %b exp 0", FlushW); end
    tick(); tick();
    checks++; if (StallF !== 1'b0 || mem_busy !== 1'b0) begin errors++; $display("FAIL reset_hold: StallF=%b busy=%b exp 0 0", StallF, mem_busy); end
    MemReqM = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_forwarding();
    Ra1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
    #1;
    checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_wins: got %b exp 10", ForwardAE); end
    RegWriteM = 1'b0;
    #1;
    checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w: got %b exp 01", ForwardAE); end
    checks++; if (ForwardBE !== 2'b00) begin errors++; $display("FAIL fwd_b_none: got %b exp 00", ForwardBE); end
    Ra2E = 4'd7; WA3W = 4'd7; WA3M = 4'd7; RegWriteM = 1'b1;
    #1;
    checks++; if (ForwardBE !== 2'b10 || ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_b_m: got A=%b B=%b exp A=00 B=10", ForwardAE, ForwardBE); end
    Ra1E = 4'd15; WA3M = 4'd15; WA3W = 4'd15; RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1;
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_pc: got %b exp 00", ForwardAE); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    tick();
    MemtoRegE = 1'b1; WA3E = 4'd5; Ra2D = 4'd5; Ra1D = 4'd0;
    #1;
    checks++; if ({StallF, StallD, FlushE} !== 3'b111) begin errors++; $display("FAIL ld_stall: got F/D/FE=%b exp 111", {StallF, StallD, FlushE}); end
    checks++; if ({FlushD, StallE, StallM} !== 3'b000) begin errors++; $display("FAIL ld_noside: got FD/SE/SM=%b exp 000", {FlushD, StallE, StallM}); end
    tick();
    clear_inputs();
    #1;
    checks++; if (StallF !== 1'b0) begin errors++; $display("FAIL ld_release: got %b exp 0", StallF); end
    checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL ld_count: got %0d exp 1", stall_cycles); end
    MemtoRegE = 1'b1; WA3E = 4'd5; Ra1D = 4'd4; Ra2D = 4'd6;
    #1;
    checks++; if (StallF !== 1'b0) begin errors++; $display("FAIL ld_nomatch: got %b exp 0", StallF); end
    MemtoRegE = 1'b0; Ra1D = 4'd5;
    #1;
    checks++; if (StallF !== 1'b0) begin errors++; $display("FAIL ld_notload: got %b exp 0", StallF); end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    tick();
    MemReqM = 1'b1;
    #1;
    checks++; if ({StallF, StallM, FlushW, mem_busy} !== 4'b1110) begin errors++; $display("FAIL mem_idle: got F/M/W/busy=%b exp 1110", {StallF, StallM, FlushW, mem_busy}); end
    checks++; if ({StallM0, mem_busy0} !== 2'b00) begin errors++; $display("FAIL mem_lat0: got M/busy=%b exp 00", {StallM0, mem_busy0}); end
    tick();
    checks++; if ({StallM, StallE, mem_busy} !== 3'b111) begin errors++; $display("FAIL mem_wait: got M/E/busy=%b exp 111", {StallM, StallE, mem_busy}); end
    tick();
    checks++; if ({StallM, FlushW, mem_busy} !== 3'b001) begin errors++; $display("FAIL mem_grant: got M/W/busy=%b exp 001", {StallM, FlushW, mem_busy}); end
    tick();
    checks++; if ({StallM, mem_busy} !== 2'b10) begin errors++; $display("FAIL b2b_idle: got M/busy=%b exp 10", {StallM, mem_busy}); end
    tick();
    checks++; if ({StallM, mem_busy} !== 2'b11) begin errors++; $display("FAIL b2b_wait: got M/busy=%b exp 11", {StallM, mem_busy}); end
    tick();
    checks++; if ({StallM, mem_busy} !== 2'b01) begin errors++; $display("FAIL b2b_grant: got M/busy=%b exp 01", {StallM, mem_busy}); end
    MemReqM = 1'b0;
    tick();
    checks++; if ({StallM, mem_busy} !== 2'b00) begin errors++; $display("FAIL mem_done: got M/busy=%b exp 00", {StallM, mem_busy}); end
    checks++; if (stall_cycles !== 4'd5) begin errors++; $display("FAIL mem_count: got %0d exp 5", stall_cycles); end
  endtask

  task automatic test_branch_during_wait();
    MemReqM = 1'b1; PCSrcE = 1'b1;
    #1;
    checks++; if ({FlushD, FlushE, StallF} !== 3'b001) begin errors++; $display("FAIL br_idle_mask: got FD/FE/SF=%b exp 001", {FlushD, FlushE, StallF}); end
    tick();
    checks++; if ({FlushD, FlushE, StallD} !== 3'b001) begin errors++; $display("FAIL br_wait_mask: got FD/FE/SD=%b exp 001", {FlushD, FlushE, StallD}); end
    tick();
    checks++; if ({FlushD, FlushE, StallF} !== 3'b110) begin errors++; $display("FAIL br_grant: got FD/FE/SF=%b exp 110", {FlushD, FlushE, StallF}); end
    MemReqM = 1'b0; MemtoRegE = 1'b1; WA3E = 4'd5; Ra1D = 4'd5;
    #1;
    checks++; if ({FlushD, FlushE, StallF} !== 3'b111) begin errors++; $display("FAIL br_and_ld: got FD/FE/SF=%b exp 111", {FlushD, FlushE, StallF}); end
    tick();
    clear_inputs();
    #1;
    checks++; if (stall_cycles !== 4'd8) begin errors++; $display("FAIL br_count: got %0d exp 8", stall_cycles); end
  endtask

  task automatic test_reset_mid_wait();
    MemReqM = 1'b1;
    tick();
    checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL rw_busy: got %b exp 1", mem_busy); end
    rst = 1'b0;
    #1;
    checks++; if ({mem_busy, StallM, StallF} !== 3'b000) begin errors++; $display("FAIL rw_drop: got busy/M/F=%b exp 000", {mem_busy, StallM, StallF}); end
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL rw_count: got %0d exp 0", stall_cycles); end
    MemReqM = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    tick();
    MemtoRegE = 1'b1; WA3E = 4'd9; Ra1D = 4'd9;
    repeat (14) tick();
    checks++; if (stall_cycles !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d exp 14", stall_cycles); end
    repeat (6) tick();
    checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_15: got %0d exp 15", stall_cycles); end
    checks++; if (stall_cycles0 !== 4'd15) begin errors++; $display("FAIL sat_lat0: got %0d exp 15", stall_cycles0); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_branch_during_wait();
    test_reset_mid_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
